// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
// Holds the FSM state encoding, digit thresholds and the width helper that
// the top module uses to reject an undersized binary output at elaboration.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // Largest legal BCD digit value.
    localparam logic [3:0] DIGIT_MAX  = 4'd9;
    // Digits at or above this value get 3 subtracted after each right shift.
    localparam logic [3:0] ADJ_THRESH = 4'd8;

    // Smallest binary width w with 2^w > 10^digits - 1.
    function automatic int bcd2bin_min_width(input int digits);
        longint unsigned max_val;
        int              w;
        max_val = 64'd1;
        for (int i = 0; i < digits; i++) begin
            max_val = max_val * 64'd10;
        end
        max_val = max_val - 64'd1;
        w = 0;
        for (int i = 0; i < 64; i++) begin
            if ((64'd1 << w) <= max_val) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Purpose: one-digit correction step of reverse double-dabble (>=8 -> minus 3).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of dig_in.
// Ports: dig_in  - 4-bit digit after the right shift
//        dig_out - corrected digit (unsigned 4-bit, no borrow out)
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] dig_in,
    output logic [3:0] dig_out
);

    always_comb begin
        dig_out = dig_in;
        if (dig_in >= ADJ_THRESH) begin
            dig_out = dig_in - 4'd3;
        end
    end

endmodule

// File: rtl/bcd2bin_seq.sv
// Purpose: sequential BCD-to-binary converter, reverse double-dabble (shift right, subtract 3).
// Latency: start accepted at edge N -> done pulses in the cycle after edge N+BIN_W+1.
// Backpressure: start/busy/done handshake; start is ignored unless IDLE, nothing is queued.
// Ports: clk, rst_n (async active-low); start + bcd_in (digit 0 in [3:0]) request a
//        conversion; busy covers load through the shift phase; done is a one-cycle
//        pulse with bin_out/err valid; bin_out/err hold until the next DONE.
// Optional: define BCD2BIN_DIGIT_CHECK_EN to flag digits >9 via err (bin_out forced to 0,
//        shift phase skipped, done two edges after the accept).
module bcd2bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    // Refuse to build if bin_out cannot hold the largest BCD input.
    if (BIN_W < bcd2bin_min_width(DIGITS)) begin : g_width_check
        $error("bcd2bin_seq: BIN_W too small for DIGITS");
    end

    state_t             state_q,   state_d;
    logic [SR_W-1:0]    sr_q,      sr_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic [BIN_W-1:0]   bin_out_q, bin_out_d;
    logic               err_q,     err_d;
    // Invalid-digit latch captured at accept; err_q only follows it on DONE.
    logic               dig_err_q, dig_err_d;

    logic               in_bad;
    logic [SR_W-1:0]    sr_shift;
    logic [BCD_W-1:0]   bcd_adj;

`ifdef BCD2BIN_DIGIT_CHECK_EN
    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > DIGIT_MAX) begin
                in_bad = 1'b1;
            end
        end
    end
`else
    assign in_bad = 1'b0;
`endif

    assign sr_shift = sr_q >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .dig_in  (sr_shift[BIN_W + 4*g +: 4]),
            .dig_out (bcd_adj[4*g +: 4])
        );
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bin_out_d = bin_out_q;
        err_d     = err_q;
        dig_err_d = dig_err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d      = {bcd_in, {BIN_W{1'b0}}};
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    dig_err_d = in_bad;
                    state_d   = CONV;
                end
            end
            CONV: begin
                if (dig_err_q) begin
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    sr_d = {bcd_adj, sr_shift[BIN_W-1:0]};
                    // cnt_q counts shifts already done; this cycle does shift cnt_q+1,
                    // so the BIN_W-th shift happens while cnt_q == BIN_W-1.
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                done_d    = 1'b1;
                bin_out_d = dig_err_q ? {BIN_W{1'b0}} : sr_q[BIN_W-1:0];
                err_d     = dig_err_q;
                state_d   = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bin_out_q <= '0;
            err_q     <= 1'b0;
            dig_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bin_out_q <= bin_out_d;
            err_q     <= err_d;
            dig_err_q <= dig_err_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bin_out = bin_out_q;
    assign err     = err_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Scoreboard bench for bcd2bin_seq: the driver pushes the expected result and
// expected completion cycle per accepted start; a monitor pops on every done.
module tb_bcd2bin_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] bcd_in;
    logic        busy;
    logic        done;
    logic [9:0]  bin_out;
    logic        err;

    bcd2bin_seq #(.DIGITS(3), .BIN_W(10)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .err     (err)
    );

    typedef struct {
        int   val;
        logic er;
        int   cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: positional decimal value of the BCD digits.
    function automatic bit has_bad(input logic [11:0] b);
        return (b[11:8] > 9) || (b[7:4] > 9) || (b[3:0] > 9);
    endfunction

    function automatic int ref_val(input logic [11:0] b);
        return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic exp_t make_exp(input logic [11:0] b, input int accept_cyc);
        exp_t e;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        if (has_bad(b)) begin
            e.val = 0;
            e.er  = 1'b1;
            e.cyc = accept_cyc + 2;
            return e;
        end
`endif
        e.val = ref_val(b);
        e.er  = 1'b0;
        e.cyc = accept_cyc + 11;
        return e;
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("bin_out", 32'(bin_out), 32'(e.val));
                chk("err", 32'(err), 32'(e.er));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // One conversion: start for one cycle, optional bcd_in change after accept,
    // then count busy cycles until the scoreboard drains.
    task automatic do_conv(input logic [11:0] b, input bit change, input logic [11:0] b2);
        exp_t e;
        int   n_busy;
        bit   drained;
        @(negedge clk);
        start  = 1'b1;
        bcd_in = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        if (change) bcd_in = b2;
        e = make_exp(b, cyc);
        exp_q.push_back(e);
        n_busy  = 0;
        drained = 1'b0;
        for (int t = 0; t < 60; t++) begin
            if (busy) n_busy++;
            if (exp_q.size() == 0) begin
                drained = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("conv_timeout", 32'(drained), 32'd1);
        chk("busy_cycles", 32'(n_busy), 32'(e.cyc - cyc + (e.er ? 1 : 2) - (e.er ? 1 : 2) + (e.er ? 1 : 10) - (e.cyc - cyc)));
    endtask

    initial begin
        logic [11:0] b;
        int          e0;
        bit          drained;

        rst_n  = 1'b0;
        start  = 1'b0;
        bcd_in = 12'h000;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bin_out", 32'(bin_out), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_conv(12'h255, 1'b0, 12'h0);
        do_conv(12'h999, 1'b0, 12'h0);
        do_conv(12'h000, 1'b0, 12'h0);
        do_conv(12'h001, 1'b0, 12'h0);
        do_conv(12'h123, 1'b1, 12'h777);

        // start held high: accepts every 12 edges, no extra done pulses.
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 12'h512;
        @(posedge clk);
        @(negedge clk);
        e0 = cyc;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back('{val: 512, er: 1'b0, cyc: e0 + 11 + 12 * k});
        end
        repeat (35) @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("b2b_drain", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a conversion aborts it silently.
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 12'h640;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_bin_out", 32'(bin_out), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        do_conv(12'h640, 1'b0, 12'h0);

`ifdef BCD2BIN_DIGIT_CHECK_EN
        do_conv(12'h1A3, 1'b0, 12'h0);
        do_conv(12'h103, 1'b0, 12'h0);
`endif

        // Randomized valid BCD words (plus invalid ones when the check is built in).
        for (int n = 0; n < 25; n++) begin
            b[11:8] = 4'($urandom_range(0, 9));
            b[7:4]  = 4'($urandom_range(0, 9));
            b[3:0]  = 4'($urandom_range(0, 9));
`ifdef BCD2BIN_DIGIT_CHECK_EN
            if ($urandom_range(0, 3) == 0) b[7:4] = 4'($urandom_range(10, 15));
`endif
            do_conv(b, 1'b0, 12'h0);
        end

        drained = (exp_q.size() == 0);
        chk("final_drain", 32'(drained), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
